// File: rtl/charmap_writer_if.sv
// Bus between the CPU/video side and the character-map writer:
// print strobe, video fetch port and cursor/status outputs.
interface charmap_writer_if #(
    parameter int CW = 7,
    parameter int RW = 5
);
    logic          charprint;
    logic [7:0]    chardata;
    logic [CW-1:0] vid_col;
    logic [RW-1:0] vid_row;
    logic [7:0]    vid_char;
    logic [CW-1:0] cursor_col;
    logic [RW-1:0] cursor_row;
    logic          busy;
    logic          overflow;

    modport master (
        output charprint, chardata, vid_col, vid_row,
        input  vid_char, cursor_col, cursor_row, busy, overflow
    );

    modport slave (
        input  charprint, chardata, vid_col, vid_row,
        output vid_char, cursor_col, cursor_row, busy, overflow
    );
endinterface

// File: rtl/charmap_writer.sv
// Character-map writer: buffers CPU print strobes in a small FIFO,
// interprets control codes, tracks a text cursor and writes codes into a
// COLS x ROWS character RAM whose second port feeds the video scanner.
module charmap_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CW     = 7,
    parameter int RW     = 5,
    parameter int AW     = 12,
    parameter int FDEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    charmap_writer_if.slave bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int PW    = $clog2(FDEPTH);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_idx, w_clr_idx_nxt;
    logic [CW-1:0] r_cur_col, w_cur_col_nxt;
    logic [RW-1:0] r_cur_row, w_cur_row_nxt;

    logic [7:0]    r_fifo [FDEPTH];
    logic [PW:0]   r_wptr, r_rptr;
    logic [PW:0]   w_count;
    logic          w_empty, w_full, w_pop, w_push;
    logic [7:0]    w_head;
    logic          r_overflow;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic [7:0]    r_ram [CELLS];

    logic [AW-1:0] w_cur_addr, w_vaddr;
    logic          w_vid_ok, w_col_last;
    logic [RW-1:0] w_row_next;
    logic [7:0]    r_vid_char;

    // FIFO status; pops only happen while idle
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (PW+1)'(FDEPTH));
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_push  = bus.charprint && (!w_full || w_pop);
    assign w_head  = r_fifo[r_rptr[PW-1:0]];

    // Cursor helpers
    assign w_cur_addr = AW'(r_cur_row) * AW'(COLS) + AW'(r_cur_col);
    assign w_col_last = (int'(r_cur_col) == COLS - 1);
    assign w_row_next = (int'(r_cur_row) == ROWS - 1) ? '0 : r_cur_row + RW'(1);

    // Video fetch address and range check
    assign w_vaddr  = AW'(bus.vid_row) * AW'(COLS) + AW'(bus.vid_col);
    assign w_vid_ok = (int'(bus.vid_col) < COLS) && (int'(bus.vid_row) < ROWS);

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (PW+1)'(1);
            if (bus.charprint && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr[PW-1:0]] <= bus.chardata;
    end

    // State, clear index and cursor registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_cur_col <= '0;
            r_cur_row <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_cur_col <= w_cur_col_nxt;
            r_cur_row <= w_cur_row_nxt;
        end
    end

    // Next state, cursor update and RAM write decode
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_cur_col_nxt = r_cur_col;
        w_cur_row_nxt = r_cur_row;
        w_we          = 1'b0;
        w_waddr       = w_cur_addr;
        w_wdata       = 8'h20;
        unique case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                if (r_clr_idx == AW'(CELLS - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + AW'(1);
                end
            end
            ST_IDLE: begin
                if (w_pop) begin
                    if (w_head >= 8'h20 && w_head <= 8'h7E) begin
                        w_we    = 1'b1;
                        w_wdata = w_head;
                        if (w_col_last) begin
                            w_cur_col_nxt = '0;
                            w_cur_row_nxt = w_row_next;
                        end else begin
                            w_cur_col_nxt = r_cur_col + CW'(1);
                        end
                    end else begin
                        case (w_head)
                            8'h0A: begin
                                w_cur_col_nxt = '0;
                                w_cur_row_nxt = w_row_next;
                            end
                            8'h0D: w_cur_col_nxt = '0;
                            8'h08: begin
                                if (r_cur_col != '0) begin
                                    w_cur_col_nxt = r_cur_col - CW'(1);
                                    w_we          = 1'b1;
                                    w_waddr       = w_cur_addr - AW'(1);
                                end
                            end
                            8'h0C: begin
                                w_cur_col_nxt = '0;
                                w_cur_row_nxt = '0;
                                w_clr_idx_nxt = '0;
                                w_state_nxt   = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Character RAM write port
    always_ff @(posedge clk) begin
        if (w_we)
            r_ram[w_waddr] <= w_wdata;
    end

    // Video read port: registered, read-before-write, blank outside the screen
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_vid_char <= 8'h20;
        else if (!w_vid_ok)
            r_vid_char <= 8'h20;
        else
            r_vid_char <= r_ram[w_vaddr];
    end

    assign bus.vid_char   = r_vid_char;
    assign bus.cursor_col = r_cur_col;
    assign bus.cursor_row = r_cur_row;
    assign bus.busy       = (r_state == ST_CLEAR);
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_charmap_writer.sv
// Bench for charmap_writer: screen/cursor/FIFO reference model checked on
// every cycle, plus directed scenarios with literal expectations.
module tb_charmap_writer;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CW     = 7;
    localparam int RW     = 5;
    localparam int AW     = 12;
    localparam int FDEPTH = 4;
    localparam int CELLS  = COLS * ROWS;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    charmap_writer_if #(.CW(CW), .RW(RW)) bus ();

    charmap_writer #(
        .COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .AW(AW), .FDEPTH(FDEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned scr   [CELLS];
    bit           known [CELLS];
    byte unsigned q[$];
    int           m_r = 0, m_c = 0, m_clr_left = 0;
    bit           m_ovf = 0;
    byte unsigned m_vid = 8'h20;
    bit           m_vid_known = 0;
    bit           cmp_en = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function void apply(input byte unsigned ch);
        int p;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            p = m_r * COLS + m_c;
            scr[p] = ch;
            known[p] = 1;
            p = (p + 1) % CELLS;
            m_r = p / COLS;
            m_c = p % COLS;
        end else if (ch == 8'h0A) begin
            m_c = 0;
            m_r = (m_r + 1) % ROWS;
        end else if (ch == 8'h0D) begin
            m_c = 0;
        end else if (ch == 8'h08) begin
            if (m_c > 0) begin
                m_c--;
                scr[m_r * COLS + m_c] = 8'h20;
                known[m_r * COLS + m_c] = 1;
            end
        end else if (ch == 8'h0C) begin
            m_r = 0;
            m_c = 0;
            m_clr_left = CELLS;
        end
    endfunction

    // Model step: video read sees the pre-edge screen, then clear/pop, then push
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_r = 0;
            m_c = 0;
            m_ovf = 0;
            m_vid = 8'h20;
            m_vid_known = 1;
            m_clr_left = CELLS;
        end else begin
            int vc, vr, a;
            vc = int'(bus.vid_col);
            vr = int'(bus.vid_row);
            if (vc < COLS && vr < ROWS) begin
                a = vr * COLS + vc;
                m_vid = scr[a];
                m_vid_known = known[a];
            end else begin
                m_vid = 8'h20;
                m_vid_known = 1;
            end
            if (m_clr_left > 0) begin
                a = CELLS - m_clr_left;
                scr[a] = 8'h20;
                known[a] = 1;
                m_clr_left--;
            end else if (q.size() > 0) begin
                apply(q.pop_front());
            end
            if (bus.charprint === 1'b1) begin
                if (q.size() < FDEPTH) q.push_back(bus.chardata);
                else m_ovf = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", int'(bus.busy), int'(m_clr_left > 0));
            check("cursor_col", int'(bus.cursor_col), m_c);
            check("cursor_row", int'(bus.cursor_row), m_r);
            check("overflow", int'(bus.overflow), int'(m_ovf));
            if (m_vid_known)
                check("vid_char", int'(bus.vid_char), int'(m_vid));
        end
    end

    task automatic print(input byte unsigned ch);
        @(negedge clk);
        #2;
        bus.charprint = 1'b1;
        bus.chardata  = ch;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        #2;
        bus.charprint = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        @(negedge clk);
        #2;
        bus.vid_row = RW'(r);
        bus.vid_col = CW'(c);
        @(negedge clk);
        v = int'(bus.vid_char);
    endtask

    task automatic count_busy(output int n);
        int w;
        w = 0;
        while (bus.busy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic byte unsigned rnd_print();
        return 8'($urandom_range(32, 126));
    endfunction

    function automatic byte unsigned rnd_code();
        int r;
        r = $urandom_range(0, 999);
        if (r < 700) return rnd_print();
        if (r < 780) return 8'h0A;
        if (r < 830) return 8'h0D;
        if (r < 930) return 8'h08;
        if (r < 931) return 8'h0C;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int n, v;
        byte unsigned s [6];
        bus.charprint = 1'b0;
        bus.chardata  = 8'h00;
        bus.vid_col   = '0;
        bus.vid_row   = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        cmp_en = 1;
        check("rst_busy", int'(bus.busy), 1);
        check("rst_vid", int'(bus.vid_char), 8'h20);
        check("rst_col", int'(bus.cursor_col), 0);
        check("rst_row", int'(bus.cursor_row), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        cycles(2);
        #2 reset = 1'b0;
        count_busy(n);
        check("clear_len", n, CELLS);

        // Full-screen sweep after the initial clear
        for (int k = 0; k <= CELLS; k++) begin
            @(negedge clk);
            if (k > 0) check("sweep", int'(bus.vid_char), 8'h20);
            #2;
            if (k < CELLS) begin
                bus.vid_row = RW'(k / COLS);
                bus.vid_col = CW'(k % COLS);
            end
        end
        read_cell(0, 80, v);   check("oor_col", v, 8'h20);
        read_cell(30, 0, v);   check("oor_row", v, 8'h20);
        read_cell(31, 127, v); check("oor_both", v, 8'h20);
        check("post_clr_col", int'(bus.cursor_col), 0);
        check("post_clr_ovf", int'(bus.overflow), 0);

        // Two characters back-to-back
        print(8'h41); print(8'h42); drive_idle();
        @(negedge clk);
        check("ab_col", int'(bus.cursor_col), 2);
        check("ab_row", int'(bus.cursor_row), 0);
        read_cell(0, 0, v); check("cell_0_0", v, 8'h41);
        read_cell(0, 1, v); check("cell_0_1", v, 8'h42);

        // Bottom-right wrap
        print(8'h0D);
        repeat (29) print(8'h0A);
        repeat (79) print(rnd_print());
        drive_idle(); cycles(2);
        check("br_col", int'(bus.cursor_col), 79);
        check("br_row", int'(bus.cursor_row), 29);
        print(8'h5A); drive_idle(); cycles(2);
        check("wrap_col", int'(bus.cursor_col), 0);
        check("wrap_row", int'(bus.cursor_row), 0);
        read_cell(29, 79, v); check("cell_29_79", v, 8'h5A);

        // Newline from (5,10), backspace at column 0
        repeat (5) print(8'h0A);
        repeat (10) print(rnd_print());
        print(8'h0A); drive_idle(); cycles(2);
        check("nl_col", int'(bus.cursor_col), 0);
        check("nl_row", int'(bus.cursor_row), 6);
        print(8'h08); drive_idle(); cycles(2);
        check("bs0_col", int'(bus.cursor_col), 0);
        check("bs0_row", int'(bus.cursor_row), 6);

        // Form feed with 'A' queued behind it
        print(8'h0C); print(8'h41); drive_idle();
        count_busy(n);
        check("ff_len", n, CELLS);
        cycles(2);
        read_cell(0, 0, v); check("ff_cell", v, 8'h41);
        check("ff_col", int'(bus.cursor_col), 1);

        // Backspace from (3,4)
        print(8'h0D);
        repeat (3) print(8'h0A);
        repeat (4) print(rnd_print());
        print(8'h08); drive_idle(); cycles(2);
        check("bs_col", int'(bus.cursor_col), 3);
        check("bs_row", int'(bus.cursor_row), 3);
        read_cell(3, 3, v); check("bs_cell", v, 8'h20);

        // Reset at clear index 1000, then overflow during the restarted clear
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
        cycles(1000);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) s[i] = rnd_print();
        #2 reset = 1'b0;
        bus.charprint = 1'b1;
        bus.chardata  = s[0];
        n = 0;
        while (bus.busy === 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            #2;
            if (n < 6) bus.chardata = s[n];
            else bus.charprint = 1'b0;
        end
        bus.charprint = 1'b0;
        check("rst_clear_len", n, CELLS);
        check("ovf_set", int'(bus.overflow), 1);
        cycles(6);
        check("ovf_col", int'(bus.cursor_col), 4);
        for (int i = 0; i < 4; i++) begin
            read_cell(0, i, v);
            check("ovf_cell", v, int'(s[i]));
        end
        read_cell(0, 4, v); check("ovf_lost", v, 8'h20);
        check("ovf_sticky", int'(bus.overflow), 1);

        // Randomized traffic
        repeat (6000) begin
            @(negedge clk);
            #2;
            bus.charprint = ($urandom_range(0, 2) != 0);
            bus.chardata  = rnd_code();
            if ($urandom_range(0, 7) == 0) begin
                bus.vid_col = CW'($urandom_range(0, 127));
                bus.vid_row = RW'($urandom_range(0, 31));
            end else begin
                bus.vid_col = CW'($urandom_range(0, COLS - 1));
                bus.vid_row = RW'($urandom_range(0, ROWS - 1));
            end
        end
        drive_idle();
        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/charmap_writer.md
Name: charmap_writer

Overview:
- Downstream consumer of the CPU's charprint strobe. It buffers the characters the CPU prints.
- It interprets control codes and maintains a text cursor.
- It writes character codes into a dual-port character RAM of COLS x ROWS cells.
- A second, read-only port serves the video scanner, which turns cells into pixels.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- CW, 7, width of column indices; must satisfy 2^CW >= COLS.
- RW, 5, width of row indices; must satisfy 2^RW >= ROWS.
- AW, 12, RAM address width; must satisfy 2^AW >= COLS*ROWS.
- FDEPTH, 4, input FIFO depth; must be a power of 2.

Ports:
- clk  in  1  system clock; same clock as the CPU.
- reset  in  1  asynchronous reset, active-high.
- charprint  in  1  one-cycle print strobe from the CPU controller.
- chardata  in  8  character code, writedata[7:0]; sampled when charprint=1.
- vid_col  in  CW  column being fetched by the video scanner.
- vid_row  in  RW  row being fetched by the video scanner.
- vid_char  out  8  registered character code at (vid_row, vid_col).
- cursor_col  out  CW  current cursor column.
- cursor_row  out  RW  current cursor row.
- busy  out  1  high while a screen clear is in progress.
- overflow  out  1  sticky flag: a print was dropped because the FIFO was full.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Values after reset:
  - cursor = (0,0), FIFO empty, overflow = 0, vid_char = 0x20.
  - State = CLEAR with clear index 0, so busy = 1.
- Cell address = row*COLS + col, computed at AW bits with no truncation.
- FIFO:
  - charprint=1 and FIFO not full: chardata is pushed on that edge.
  - FIFO full with no pop in the same cycle: the push is dropped and overflow is set to 1. Only reset clears overflow.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - Pushes are accepted in every state, including CLEAR.
- State machine (2 states):
  - CLEAR: writes 0x20 to the cell at the clear index, one cell per cycle. The index counts 0..COLS*ROWS-1. The cycle that writes the last cell moves to IDLE. Duration is exactly COLS*ROWS cycles. No pops occur in CLEAR; cursor is held at (0,0).
  - IDLE: if the FIFO is non-empty, pop one entry per cycle and act on it in that same edge. Actions by code:
    - 0x20-0x7E: write the code at the cursor, then advance col. Past col COLS-1, col becomes 0 and row advances; past row ROWS-1, row wraps to 0. There is no scrolling.
    - 0x0A: col = 0, row advances with the same wrap rule.
    - 0x0D: col = 0.
    - 0x08: if col > 0, col decrements and 0x20 is written at the new col. At col 0 it is a no-op with no wrap to the previous row.
    - 0x0C: cursor = (0,0), clear index = 0, go to CLEAR.
    - any other code: consumed with no effect.
- Latency:
  - A strobe at edge n pushes the character.
  - The earliest pop, and the RAM write, happens at edge n+1.
  - A video read of that cell issued after edge n+1 shows the new value on vid_char after the following edge.
- Video port:
  - Synchronous read with 1-cycle latency: vid_char is updated every edge from the RAM at address (vid_row, vid_col).
  - If vid_col >= COLS or vid_row >= ROWS, vid_char = 0x20 on the next edge.
  - A simultaneous write to the same cell returns the old value (read-before-write).
- Reset mid-operation (during CLEAR or IDLE): FIFO contents are discarded and the clear restarts from index 0. RAM contents are undefined until the clear completes.

Test Plan:
- Assert reset, then release -> busy = 1 for exactly 2400 cycles. Afterwards every cell (all 80x30) reads back 0x20 via the video port, cursor = (0,0), overflow = 0.
- After the clear, strobe 0x41 then 0x42 -> cell(0,0) = 0x41 and cell(0,1) = 0x42. Cursor = (0,2) two edges after the second strobe.
- Cursor at row 29, col 79; print 0x5A -> cell(29,79) = 0x5A, cursor = (0,0). Then print 0x0A from (5,10) -> cursor (6,0). Then print 0x08 at col 0 -> no change.
- From cursor (3,4), print 0x08 -> cursor (3,3) and cell(3,3) = 0x20.
- Strobe 6 characters back-to-back during CLEAR -> the first 4 are printed at (0,0)..(0,3) after busy falls. The last 2 are lost and overflow = 1.
- Print 0x0C with 'A' queued behind it -> busy = 1 for 2400 cycles, then 'A' is written at (0,0). Assert reset at clear index 1000 -> the clear restarts and lasts a full 2400 cycles from reset release.
